// File: rtl/shift_register_burst.sv
// shift_register_burst: parametrised universal shift register with a burst sequencer.
//   clk, rst_n          : rising-edge clock, asynchronous active-low reset
//   mode[2:0]           : operation select (hold/shl/shr/rol/ror/load/clear/asr)
//   sin_r, sin_l        : serial inputs into LSB (shift left) / MSB (logical shift right)
//   pin[WIDTH-1:0]      : parallel load data
//   start, len          : request a burst of len applications of the latched mode
//   q                   : register contents
//   sout_l, sout_r      : q MSB / q LSB (combinational)
//   busy, done          : burst in progress / one-cycle completion pulse
module shift_register_burst #(
    parameter int unsigned WIDTH = 6,
    parameter int unsigned LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       mode,
    input  logic             sin_r,
    input  logic             sin_l,
    input  logic [WIDTH-1:0] pin,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    output logic [WIDTH-1:0] q,
    output logic             sout_l,
    output logic             sout_r,
    output logic             busy,
    output logic             done
);

    localparam logic [2:0] MODE_HOLD  = 3'b000;
    localparam logic [2:0] MODE_SHL   = 3'b001;
    localparam logic [2:0] MODE_SHR   = 3'b010;
    localparam logic [2:0] MODE_ROL   = 3'b011;
    localparam logic [2:0] MODE_ROR   = 3'b100;
    localparam logic [2:0] MODE_LOAD  = 3'b101;
    localparam logic [2:0] MODE_CLEAR = 3'b110;
    localparam logic [2:0] MODE_ASR   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [2:0]       mode_q, mode_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // One application of an operation to the current register value.
    function automatic logic [WIDTH-1:0] apply_op(
        input logic [2:0]       m,
        input logic [WIDTH-1:0] cur,
        input logic             s_r,
        input logic             s_l,
        input logic [WIDTH-1:0] p
    );
        logic [WIDTH-1:0] r;
        r = cur;
        case (m)
            MODE_HOLD:  r = cur;
            MODE_SHL:   r = {cur[WIDTH-2:0], s_r};
            MODE_SHR:   r = {s_l, cur[WIDTH-1:1]};
            MODE_ROL:   r = {cur[WIDTH-2:0], cur[WIDTH-1]};
            MODE_ROR:   r = {cur[0], cur[WIDTH-1:1]};
            MODE_LOAD:  r = p;
            MODE_CLEAR: r = '0;
            MODE_ASR:   r = {cur[WIDTH-1], cur[WIDTH-1:1]};
            default:    r = cur;
        endcase
        return r;
    endfunction

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            mode_q  <= '0;
            q_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            q_q     <= q_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state, counter and datapath selection.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        q_d     = q_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    // A burst start leaves q untouched on the start edge.
                    if (len != '0) begin
                        mode_d  = mode;
                        cnt_d   = len;
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else begin
                    q_d = apply_op(mode, q_q, sin_r, sin_l, pin);
                end
            end
            ST_RUN: begin
                // Only the mode is latched; serial and parallel data are live.
                q_d   = apply_op(mode_q, q_q, sin_r, sin_l, pin);
                cnt_d = cnt_q - LEN_W'(1);
                if (cnt_q == LEN_W'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Status flags are registered decodes of the next state.
        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    assign q      = q_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign sout_l = q_q[WIDTH-1];
    assign sout_r = q_q[0];

endmodule
